// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared NoC router constants: output-port indices and the packet
//            header field layout.
// Revision : 1.0
// ============================================================================
package noc_pkg;

    localparam int DATA_W   = 64;
    localparam int HOP_W    = 4;

    localparam int PORT_PE  = 0;
    localparam int PORT_S   = 1;
    localparam int PORT_N   = 2;
    localparam int PORT_E   = 3;
    localparam int PORT_W   = 4;
    localparam int NUM_PORTS = 5;

    localparam int VC_BIT   = 63;
    localparam int DIRX_BIT = 62;
    localparam int DIRY_BIT = 61;
    localparam int HOPX_MSB = 55;
    localparam int HOPX_LSB = 52;
    localparam int HOPY_MSB = 51;
    localparam int HOPY_LSB = 48;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/ipctrl_vc_if.sv
`default_nettype none
// ============================================================================
// Module   : ipctrl_vc_if
// Purpose  : Link-side and core-side signal bundle of the input port controller.
// Revision : 1.0
// ============================================================================
interface ipctrl_vc_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic              polarity;
    logic              send_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic [4:0]        req;
    logic [DATA_W-1:0] data_out;
    logic              clear;
    logic              vc_err;
    logic [CNT_W-1:0]  pkt_cnt;

    modport master (
        output polarity, send_in, data_in, clear,
        input  ready_in, req, data_out, vc_err, pkt_cnt
    );

    modport slave (
        input  polarity, send_in, data_in, clear,
        output ready_in, req, data_out, vc_err, pkt_cnt
    );
endinterface : ipctrl_vc_if
`default_nettype wire

// File: rtl/ipctrl_vc_xy_route.sv
`default_nettype none
// ============================================================================
// Module   : xy_route
// Purpose  : Combinational XY router: one-hot output request plus the packet
//            with the hop count of the routed dimension decremented.
// Revision : 1.0
// ============================================================================
module xy_route
    import noc_pkg::*;
#(
    parameter int DATA_W = noc_pkg::DATA_W,
    parameter int HOP_W  = noc_pkg::HOP_W
) (
    input  wire logic [DATA_W-1:0] pkt,
    output logic      [4:0]        req,
    output logic      [DATA_W-1:0] pkt_out
);

    logic [HOP_W-1:0] w_hop_x;
    logic [HOP_W-1:0] w_hop_y;

    assign w_hop_x = pkt[HOPX_LSB +: HOP_W];
    assign w_hop_y = pkt[HOPY_LSB +: HOP_W];

    // X is exhausted before Y; a packet with both hops at zero has arrived
    always_comb begin
        req     = '0;
        pkt_out = pkt;
        if (w_hop_x != '0) begin
            if (pkt[DIRX_BIT]) req[PORT_E] = 1'b1;
            else               req[PORT_W] = 1'b1;
            pkt_out[HOPX_LSB +: HOP_W] = w_hop_x - 1'b1;
        end else if (w_hop_y != '0) begin
            if (pkt[DIRY_BIT]) req[PORT_N] = 1'b1;
            else               req[PORT_S] = 1'b1;
            pkt_out[HOPY_LSB +: HOP_W] = w_hop_y - 1'b1;
        end else begin
            req[PORT_PE] = 1'b1;
        end
    end

endmodule : xy_route
`default_nettype wire

// File: rtl/ipctrl_vc.sv
`default_nettype none
// ============================================================================
// Module   : ipctrl_vc
// Purpose  : Router input port controller with two single-packet VC buffers;
//            the link fills VC ~polarity while the core drains VC polarity.
// Revision : 1.0
// ============================================================================
module ipctrl_vc
    import noc_pkg::*;
#(
    parameter int DATA_W = noc_pkg::DATA_W,
    parameter int HOP_W  = noc_pkg::HOP_W,
    parameter int CNT_W  = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    ipctrl_vc_if.slave  bus
);

    logic [DATA_W-1:0] r_buf [2];
    logic [1:0]        r_full;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic              r_vc_err;

    logic              w_link_vc;
    logic              w_core_vc;
    logic              w_ready;
    logic              w_write;
    logic [DATA_W-1:0] w_core_pkt;
    logic [4:0]        w_route_req;
    logic [DATA_W-1:0] w_route_pkt;

    assign w_link_vc = ~bus.polarity;
    assign w_core_vc = bus.polarity;
    assign w_ready   = ~r_full[w_link_vc];
    assign w_write   = bus.send_in && w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
            r_full    <= '0;
            r_pkt_cnt <= '0;
            r_vc_err  <= 1'b0;
        end else begin
            r_vc_err <= 1'b0;
            // Core and link always address opposite buffers, so clear and write never collide
            if (bus.clear) begin
                r_full[w_core_vc] <= 1'b0;
            end
            if (w_write) begin
                if (bus.data_in[VC_BIT] == w_link_vc) begin
                    r_buf[w_link_vc]  <= bus.data_in;
                    r_full[w_link_vc] <= 1'b1;
                    r_pkt_cnt         <= r_pkt_cnt + 1'b1;
                end else begin
                    r_vc_err <= 1'b1;
                end
            end
        end
    end

    assign w_core_pkt = r_full[w_core_vc] ? r_buf[w_core_vc] : '0;

    xy_route #(
        .DATA_W (DATA_W),
        .HOP_W  (HOP_W)
    ) u_xy_route (
        .pkt     (w_core_pkt),
        .req     (w_route_req),
        .pkt_out (w_route_pkt)
    );

    // An empty buffer must not request PE even though a zero header routes there
    assign bus.req      = r_full[w_core_vc] ? w_route_req : 5'b00000;
    assign bus.data_out = r_full[w_core_vc] ? w_route_pkt : '0;
    assign bus.ready_in = w_ready;
    assign bus.vc_err   = r_vc_err;
    assign bus.pkt_cnt  = r_pkt_cnt;

endmodule : ipctrl_vc
`default_nettype wire
